// File: rtl/ads127l01_pkg.sv
// Shared types and constants for the ADS127L01 frame-sync transmitter.
package ads127l01_pkg;

  // Transmitter states: IDLE keeps the serial pins quiet, RUN streams frames.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Optional status byte appended after the sample bits.
  localparam int STATUS_BITS = 8;

  // The status byte carries {underrun, frame_cnt}, so the counter fills the rest.
  localparam int FRAME_CNT_W = STATUS_BITS - 1;

endpackage

// File: rtl/ads127l01_sck_gen.sv
// Serial clock generator: divides clk into sck and flags each sck falling edge.
// sck stays low for the first SCK_DIV clk after run rises, then toggles every
// SCK_DIV clk. fall is high for the single clk whose edge takes sck 1->0.
module ads127l01_sck_gen #(
  parameter int SCK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic sck,
  output logic fall
);

  localparam int DIVW = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(SCK_DIV - 1);

  logic            active;
  logic [DIVW-1:0] div;
  logic            tick;

  // The divider only counts once run has been seen for a full clk, which keeps
  // the first half-period the same length as every other one.
  assign tick = run & active & (div == DIV_LAST);
  assign fall = tick & sck;

  // Remember whether the previous clk was already running.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) active <= 1'b0;
    else     active <= run;
  end

  // Half-period divider and sck toggle; both clear as soon as run drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div <= '0;
      sck <= 1'b0;
    end else if (!run) begin
      div <= '0;
      sck <= 1'b0;
    end else if (active) begin
      if (div == DIV_LAST) begin
        div <= '0;
        sck <= ~sck;
      end else begin
        div <= div + DIVW'(1);
      end
    end
  end

endmodule

// File: rtl/ads127l01_fsync_tx.sv
// ADS127L01-style frame-sync serial transmitter.
// Each frame is FRAME_BITS sck periods: fsync marks bit 0, dout carries the
// sample MSB-first followed by zeros. Define ADS127L01_TX_STATUS_EN to append
// a status byte {underrun, frame_cnt[6:0]} right after the sample bits.
//
// Sample stream handshake: a word moves when s_axis_tvalid and s_axis_tready
// are both high at a clk edge; the source holds tvalid/tdata until then, and
// tready (en & ~buf_valid) never depends on tvalid.
module ads127l01_fsync_tx
  import ads127l01_pkg::*;
#(
  parameter int DW         = 24,
  parameter int FRAME_BITS = 32,
  parameter int SCK_DIV    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          start,
  input  logic          reset_n,
  input  logic          s_axis_tvalid,
  output logic          s_axis_tready,
  input  logic [DW-1:0] s_axis_tdata,
  output logic          sck,
  output logic          fsync,
  output logic          dout,
  output logic          underrun,
  output state_t        state_dbg
);

  localparam int BCW = 8;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(FRAME_BITS - 1);

  if (FRAME_BITS < DW || FRAME_BITS > 255) begin : g_bad_frame_bits
    $error("FRAME_BITS must lie in DW..255");
  end
  if (SCK_DIV < 1) begin : g_bad_sck_div
    $error("SCK_DIV must be at least 1");
  end
`ifdef ADS127L01_TX_STATUS_EN
  if (FRAME_BITS < DW + STATUS_BITS) begin : g_bad_status_room
    $error("FRAME_BITS too small to hold the sample plus the status byte");
  end
`endif

  state_t                state, state_nxt;
  logic                  run;
  logic                  fall;
  logic                  frame_load;
  logic [BCW-1:0]        bit_cnt;
  logic [FRAME_BITS-1:0] shreg;
  logic [FRAME_BITS-1:0] load_word;
  logic                  buf_valid;
  logic [DW-1:0]         buf_data;
  logic                  xfer;

  assign run           = en & start & reset_n;
  assign s_axis_tready = en & ~buf_valid;
  assign xfer          = s_axis_tvalid & s_axis_tready;
  assign state_dbg     = state;

  // Outputs are decoded from registers only, so an async rst clears them at once.
  assign fsync = (state == RUN) && (bit_cnt == '0);
  assign dout  = (state == RUN) && shreg[FRAME_BITS-1];

  ads127l01_sck_gen #(
    .SCK_DIV(SCK_DIV)
  ) u_sck_gen (
    .clk (clk),
    .rst (rst),
    .run (run),
    .sck (sck),
    .fall(fall)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and bit-0 boundary detection (entry into RUN or frame wrap).
  always_comb begin
    state_nxt  = state;
    frame_load = 1'b0;
    case (state)
      IDLE: begin
        if (run) begin
          state_nxt  = RUN;
          frame_load = 1'b1;
        end
      end
      RUN: begin
        if (!run) state_nxt = IDLE;
        else if (fall && bit_cnt == LAST_BIT) frame_load = 1'b1;
      end
    endcase
  end

`ifdef ADS127L01_TX_STATUS_EN
  logic [FRAME_CNT_W-1:0] frame_cnt;
  logic [FRAME_CNT_W-1:0] frame_cnt_cur;

  // A frame started on RUN entry is always frame 0, whatever was left over.
  assign frame_cnt_cur = (state == IDLE) ? '0 : frame_cnt;

  // Count frames started since RUN entry, wrapping at 7 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                frame_cnt <= '0;
    else if (frame_load)    frame_cnt <= frame_cnt_cur + FRAME_CNT_W'(1);
    else if (state == IDLE) frame_cnt <= '0;
  end
`endif

  // Frame word: buffered sample (or zeros on underrun), then optional status.
  always_comb begin
    load_word = '0;
    if (buf_valid) load_word[FRAME_BITS-1 -: DW] = buf_data;
`ifdef ADS127L01_TX_STATUS_EN
    load_word[FRAME_BITS-1-DW -: STATUS_BITS] = {underrun, frame_cnt_cur};
`endif
  end

  // Bit counter advances on every sck fall and restarts whenever RUN is left.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         bit_cnt <= '0;
    else if (state != RUN || !run)   bit_cnt <= '0;
    else if (fall)                   bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + BCW'(1);
  end

  // Shift register: loads at each bit-0 boundary, shifts on each sck fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             shreg <= '0;
    else if (frame_load) shreg <= load_word;
    else if (fall)       shreg <= {shreg[FRAME_BITS-2:0], 1'b0};
  end

  // One-entry sample buffer; a word arriving on a load clk lands after the load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_valid <= 1'b0;
      buf_data  <= '0;
    end else begin
      if (frame_load) buf_valid <= 1'b0;
      if (xfer) begin
        buf_valid <= 1'b1;
        buf_data  <= s_axis_tdata;
      end
      if (!reset_n) buf_valid <= 1'b0;
    end
  end

  // Sticky underrun: set when a frame starts empty, cleared only by en low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          underrun <= 1'b0;
    else if (!en)                     underrun <= 1'b0;
    else if (frame_load && !buf_valid) underrun <= 1'b1;
  end

endmodule

// File: tb/tb_ads127l01_fsync_tx.sv
// Bench for ads127l01_fsync_tx (DW=24, FRAME_BITS=32, SCK_DIV=2).
// A time-based model predicts every output each cycle; directed sequences add
// hand-computed literal expectations. Honours ADS127L01_TX_STATUS_EN.
module tb_ads127l01_fsync_tx;
  import ads127l01_pkg::*;

  localparam int DW        = 24;
  localparam int FB        = 32;
  localparam int SD        = 2;
  localparam int BIT_CLK   = 2 * SD;
  localparam int FRAME_CLK = FB * BIT_CLK;

  // clock / reset and DUT pins
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          start = 1'b0;
  logic          reset_n = 1'b0;
  logic          s_axis_tvalid = 1'b0;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tready;
  logic          sck, fsync, dout, underrun;
  state_t        dbg_state;

  int total = 0;
  int bad   = 0;

  initial forever #5 clk = ~clk;

  ads127l01_fsync_tx #(
    .DW(DW),
    .FRAME_BITS(FB),
    .SCK_DIV(SD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .start        (start),
    .reset_n      (reset_n),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tdata (s_axis_tdata),
    .sck          (sck),
    .fsync        (fsync),
    .dout         (dout),
    .underrun     (underrun),
    .state_dbg    (dbg_state)
  );

  // ---------------- model ----------------
  typedef struct packed {
    logic          run;
    int            t;       // clk cycles since RUN entry
    logic [FB-1:0] word;    // frame currently on the wire
    logic          bv;
    logic [DW-1:0] bdata;
    logic          ur;
    int            frames;  // frames started since RUN entry
  } mstate_t;

  mstate_t m;

  function automatic mstate_t model_step(mstate_t s, logic i_en, logic i_start, logic i_rn,
                                         logic i_tv, logic [DW-1:0] i_td);
    mstate_t n = s;
    logic rdy = i_en & ~s.bv;
    logic new_frame = 1'b0;
    if (!(i_en & i_start & i_rn)) begin
      n.run = 1'b0;
      n.t   = 0;
    end else if (!s.run) begin
      n.run     = 1'b1;
      n.t       = 0;
      n.frames  = 0;
      new_frame = 1'b1;
    end else begin
      n.t       = s.t + 1;
      new_frame = (n.t % FRAME_CLK) == 0;
    end
    if (new_frame) begin
      n.word = '0;
      if (s.bv) n.word[FB-1 -: DW] = s.bdata;
      else      n.ur = 1'b1;
`ifdef ADS127L01_TX_STATUS_EN
      n.word[FB-1-DW -: 8] = {s.ur, n.frames[6:0]};
      n.frames = n.frames + 1;
`endif
      n.bv = 1'b0;
    end
    if (rdy & i_tv) begin
      n.bv    = 1'b1;
      n.bdata = i_td;
    end
    if (!i_rn) n.bv = 1'b0;
    if (!i_en) n.ur = 1'b0;
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= '0;
    else     m <= model_step(m, en, start, reset_n, s_axis_tvalid, s_axis_tdata);
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, sampled on the falling edge.
  initial begin
    int   bitn;
    logic e_sck, e_fsync, e_dout;
    @(posedge clk);
    forever begin
      @(negedge clk);
      bitn    = (m.t / BIT_CLK) % FB;
      e_sck   = m.run && ((m.t % BIT_CLK) >= SD);
      e_fsync = m.run && (bitn == 0);
      e_dout  = m.run && m.word[FB-1-bitn];
      check("m_sck", sck, e_sck);
      check("m_fsync", fsync, e_fsync);
      check("m_dout", dout, e_dout);
      check("m_tready", s_axis_tready, en & ~m.bv);
      check("m_underrun", underrun, m.ur);
      check("m_state", dbg_state, m.run ? RUN : IDLE);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] d);
    int n = 0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    while (!s_axis_tready && n < 400) begin
      step(1);
      n++;
    end
    check("push_timeout", 32'(n >= 400), 0);
    step(1);
    s_axis_tvalid = 1'b0;
  endtask

  // ---------------- directed sequences ----------------
  initial begin
    logic [7:0] pat;
    logic [7:0] st;

    // reset: quiet outputs, tready follows en, nothing captured
    step(2);
    check("rst_outs", {sck, fsync, dout, underrun}, 4'b0000);
    check("rst_tready_en0", s_axis_tready, 0);
    en = 1'b1;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 24'hDEAD01;
    #1;
    check("rst_tready_en1", s_axis_tready, 1);
    step(2);
    s_axis_tvalid = 1'b0;
    rst = 1'b0;
    step(1);
    check("no_capture_in_rst", s_axis_tready, 1);

    // first frame with 0xA5A5A5
    reset_n = 1'b1;
    push(24'hA5A5A5);
    start = 1'b1;
    step(1);
    pat = 8'hA5;
    for (int b = 0; b < FB; b++) begin
      for (int c = 0; c < BIT_CLK; c++) begin
        if (b < 2) check("a5_fsync", fsync, 32'(b == 0));
        if (b == 0) check("a5_sck", sck, 32'(c >= 2));
        if (b < 8 && c == 0) check("a5_dout", dout, pat[7-b]);
        if (b >= 24 && c == 1) check("a5_tail", dout, 0);
        step(1);
      end
    end

    // empty buffer at the next frame: zero sample and sticky underrun
    check("ur_set", underrun, 1);
    check("ur_fsync", fsync, 1);
    for (int b = 0; b < DW; b++) begin
      check("ur_zero_bit", dout, 0);
      step(BIT_CLK);
    end
    check("ur_held", underrun, 1);
    en = 1'b0;
    start = 1'b0;
    step(1);
    check("ur_clear", underrun, 0);

    // tvalid held high with two words
    en = 1'b1;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 24'h000001;
    #1;
    check("hold_rdy0", s_axis_tready, 1);
    step(1);
    s_axis_tdata = 24'h800000;
    check("hold_rdy_drop", s_axis_tready, 0);
    step(3);
    check("hold_rdy_wait", s_axis_tready, 0);
    start = 1'b1;
    step(1);
    check("hold_rdy_back", s_axis_tready, 1);
    step(1);
    s_axis_tvalid = 1'b0;
    check("hold_rdy_full", s_axis_tready, 0);
    step(91);
    check("w1_bit23", dout, 1);
    step(36);
    check("w2_fsync", fsync, 1);
    check("w2_bit0", dout, 1);
    check("w2_no_ur", underrun, 0);

    // abort at bit 10 and restart with the buffered word
    push(24'h123456);
    step(41);
    check("abort_pre_sck", sck, 1);
    start = 1'b0;
    step(1);
    check("abort_outs", {sck, fsync, dout}, 3'b000);
    step(3);
    start = 1'b1;
    step(1);
    check("restart_fsync", fsync, 1);
    check("restart_bit0", dout, 0);
    step(12);
    check("restart_bit3", dout, 1);

    // underrun, refill, then async reset mid-frame
    step(116);
    check("ur2_set", underrun, 1);
    push(24'h654321);
    step(21);
    check("mid_sck", sck, 1);
    rst = 1'b1;
    #1;
    check("arst_outs", {sck, fsync, dout}, 3'b000);
    check("arst_ur", underrun, 0);
    check("arst_buf_empty", s_axis_tready, 1);
    start = 1'b0;
    step(2);
    rst = 1'b0;
    step(1);

    // reset_n flushes the buffer; dropping en alone keeps it
    push(24'hABCDEF);
    check("buf_full", s_axis_tready, 0);
    reset_n = 1'b0;
    step(1);
    check("flush_rdy", s_axis_tready, 1);
    reset_n = 1'b1;
    push(24'h0F0F0F);
    check("buf_full2", s_axis_tready, 0);
    en = 1'b0;
    step(1);
    en = 1'b1;
    #1;
    check("keep_on_en", s_axis_tready, 0);
    start = 1'b1;
    step(1);
    check("kept_bit0", dout, 0);
    step(16);
    check("kept_bit4", dout, 1);
    step(120);

`ifdef ADS127L01_TX_STATUS_EN
    // status byte: frame counter and delayed underrun flag
    en = 1'b0;
    start = 1'b0;
    step(1);
    en = 1'b1;
    push(24'h111111);
    start = 1'b1;
    step(1);
    push(24'h222222);
    step(255);
    check("st_f2_fsync", fsync, 1);
    check("st_f2_ur", underrun, 1);
    step(96);
    st = 8'h02;
    for (int b = 0; b < 8; b++) begin
      check("st_f2_byte", dout, st[7-b]);
      step(BIT_CLK);
    end
    step(96);
    check("st_f3_msb", dout, 1);
`else
    st = 8'h00;
    check("st_unused", {24'h0, st}, 0);
`endif

    en = 1'b0;
    start = 1'b0;
    step(4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ads127l01_fsync_tx.md
ADS127L01_FSYNC_TX -- requirements
Module: ads127l01_fsync_tx

Interface
REQ-001 SHALL have parameter DW, default 24: sample width in bits.
REQ-002 SHALL have parameter FRAME_BITS, default 32: SCK periods per frame, legal range DW..255.
REQ-003 SHALL have parameter SCK_DIV, default 2: clk cycles per SCK half-period, minimum 1.
REQ-004 SHALL have port clk, input, 1: sole clock.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port en, input, 1: transmitter enable.
REQ-007 SHALL have port start, input, 1: host START pin; frames are sent only while high.
REQ-008 SHALL have port reset_n, input, 1: host device-reset pin, active-low.
REQ-009 SHALL have ports s_axis_tvalid in 1, s_axis_tready out 1, s_axis_tdata in DW: sample stream.
REQ-010 SHALL have ports sck out 1, fsync out 1, dout out 1: frame-sync serial output.
REQ-011 SHALL have port underrun, output, 1: sticky flag, set when a frame starts with no sample buffered.

Function
REQ-012 SHALL define run = en & start & reset_n; the states are IDLE and RUN.
- IDLE->RUN when run=1.
- RUN->IDLE on the first clk with run=0.
REQ-013 SHALL hold sck, fsync and dout at 0 in IDLE, clear the divider and clear the bit counter.
REQ-014 SHALL, on entering RUN, present bit 0 of frame 0 in the same clk and keep sck low; sck toggles every SCK_DIV clk thereafter.
REQ-015 SHALL advance the bit counter on each sck falling edge (registered 1->0 toggle), wrapping FRAME_BITS-1->0.
- Each bit lasts 2*SCK_DIV clk.
- Each frame lasts FRAME_BITS*2*SCK_DIV clk.
REQ-016 SHALL drive fsync=1 during bit 0 only.
REQ-017 SHALL drive dout MSB-first: bits 0..DW-1 = sample[DW-1:0]; bits DW..FRAME_BITS-1 = 0, except as set by REQ-025.
REQ-018 SHALL hold one sample in a one-entry buffer.
- s_axis_tready = en & ~buf_valid.
- A transfer occurs on tvalid & tready.
REQ-019 SHALL, at each bit-0 boundary with buf_valid=1, load the shift register from the buffer and clear buf_valid in the same clk.
- If a transfer coincides with that clk, the buffer is refilled afterwards: load takes priority and the incoming word is captured.
REQ-020 SHALL, at a bit-0 boundary with buf_valid=0, transmit an all-zero sample and set underrun.
- underrun clears only on rst or on en=0.
REQ-021 SHALL flush the buffer (buf_valid=0) while reset_n=0.
- The buffer is retained when only en or start drop.
REQ-022 SHALL abort a partial frame immediately when run falls.
- The next RUN restarts at bit 0 with the currently buffered sample.

Reset
REQ-023 SHALL, while rst=1, force: state IDLE, sck=0, fsync=0, dout=0, buf_valid=0, underrun=0, bit counter=0, divider=0, frame counter=0.
REQ-024 SHALL present s_axis_tready = en while rst=1, and SHALL NOT capture any data during rst.

Configuration
REQ-025 SHALL append a status byte when ADS127L01_TX_STATUS_EN is defined.
- The byte occupies bits DW..DW+7, MSB-first: {underrun, frame_cnt[6:0]}.
- frame_cnt is a 7-bit wrapping count of frames started since RUN entry.
- FRAME_BITS < DW+8 SHALL be an elaboration error.
REQ-026 SHALL, without ADS127L01_TX_STATUS_EN, transmit zeros after the sample bits and contain no frame counter.

Structure
REQ-027 SHALL place in shared package ads127l01_pkg:
- state enum (IDLE, RUN);
- STATUS_BITS=8;
- frame-counter width.
REQ-028 SHALL instantiate one sub-module, ads127l01_sck_gen.
- Divider and sck toggle only.
- Outputs: sck and a one-clk fall strobe.
- Inputs: clk, rst, run.

Verification (DW=24, FRAME_BITS=32, SCK_DIV=2, frame=128 clk)
REQ-029 SHALL check: push 0xA5A5A5, raise en/start/reset_n -> fsync=1 for the first 4 clk; dout = 1,0,1,0,0,1,0,1 in 4-clk bits; bits 24..31=0 (macro off).
REQ-030 SHALL check: no sample pushed at frame start -> 24 zero bits, underrun=1 and held until en low.
REQ-031 SHALL check: tvalid held high with 0x000001, 0x800000 -> tready drops after the first capture and reasserts at the next bit-0 load; samples appear in consecutive frames with no underrun.
REQ-032 SHALL check: start low at bit 10 -> sck/fsync/dout=0 next clk; start high -> fsync=1 immediately; the buffered word is sent from bit 0.
REQ-033 SHALL check: rst pulse mid-frame -> all outputs 0 asynchronously, buffer empty, underrun=0.
REQ-034 SHALL check, with ADS127L01_TX_STATUS_EN: the third frame after RUN carries status byte 0x02; after an underrun the next frame's status MSB=1.
